// File: rtl/tinyqv_trace_pkg.sv
// rtl/tinyqv_trace_pkg.sv - shared types and record layout for the tinyQV trace buffer
// Record width depends on TRACE_TIMESTAMP_EN.
package tinyqv_trace_pkg;

  localparam int FLG_BRANCH       = 0;
  localparam int FLG_EARLY_BRANCH = 1;
  localparam int FLG_RET          = 2;
  localparam int FLG_REG_WEN      = 3;
  localparam int FLG_IRQ          = 4;
  localparam int FLG_W            = 5;
  localparam int RD_W             = 4;

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    POST   = 2'd1,
    FROZEN = 2'd2
  } trace_state_e;

  // Record layout, LSB first: pc, rd, flags, [timestamp delta]
  function automatic int rec_rd_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int rec_flg_lsb(input int addr_w);
    return addr_w + RD_W;
  endfunction

  function automatic int rec_ts_lsb(input int addr_w);
    return addr_w + RD_W + FLG_W;
  endfunction

  function automatic int rec_width(input int addr_w, input int ts_w);
    return rec_ts_lsb(addr_w) + (TS_EN ? ts_w : 0);
  endfunction

endpackage

// File: rtl/tinyqv_trace_buffer_if.sv
// rtl/tinyqv_trace_buffer_if.sv - event capture and record drain signals of the trace buffer
interface tinyqv_trace_if #(
  parameter int ADDR_W = 23,
  parameter int REC_W  = 32
);
  logic              ev_complete;
  logic              ev_valid;
  logic [ADDR_W-1:0] ev_pc;
  logic [3:0]        ev_rd;
  logic [4:0]        ev_flags;
  logic              out_valid;
  logic              out_ready;
  logic [REC_W-1:0]  out_data;

  modport master (
    output ev_complete, ev_valid, ev_pc, ev_rd, ev_flags, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  ev_complete, ev_valid, ev_pc, ev_rd, ev_flags, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/tinyqv_trace_fifo.sv
// rtl/tinyqv_trace_fifo.sv - record storage with stream (drop) or ring (overwrite) full policy
module tinyqv_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     mode_ring,
  input  logic                     push,
  input  logic                     pop_req,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             full, pop, wr_en, overwrite;

  always_comb begin
    full      = (level_q == FULL_LVL);
    pop       = (level_q != '0) & pop_req;
    // A same-cycle pop frees a slot, so push+pop at full is a normal write.
    wr_en     = push & (~full | pop | mode_ring);
    overwrite = push & full & ~pop & mode_ring;
    drop      = push & full & ~pop & ~mode_ring;
    wr_ptr_d  = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop | overwrite);
    level_d   = level_q + (PTR_W+1)'(wr_en & ~overwrite) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign valid = (level_q != '0);
  assign level = level_q;
endmodule

// File: rtl/tinyqv_trace_buffer.sv
// rtl/tinyqv_trace_buffer.sv - tinyQV retired-instruction trace buffer with PC trigger
// Optional per-record timestamp deltas via TRACE_TIMESTAMP_EN.
module tinyqv_trace_buffer
  import tinyqv_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 23,
  parameter int TS_W   = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   mode_ring,
  input  logic                   clear,
  input  logic                   trig_en,
  input  logic [ADDR_W-1:0]      trig_addr,
  input  logic [$clog2(DEPTH):0] post_count,
  tinyqv_trace_if.slave          tif,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            dropped,
  output logic                   triggered,
  output logic                   frozen
);
  localparam int REC_W = rec_width(ADDR_W, TS_W);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  trace_state_e     state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             triggered_q, triggered_d;
  logic [15:0]      dropped_q, dropped_d;
  logic             accept, trig_hit, fifo_drop;
  logic [REC_W-1:0] rec;

  always_comb begin
    accept      = enable & tif.ev_complete & tif.ev_valid & (state_q != FROZEN);
    trig_hit    = accept & trig_en & (tif.ev_pc == trig_addr);
    state_d     = state_q;
    remaining_d = remaining_q;
    triggered_d = triggered_q;
    case (state_q)
      ARMED: begin
        if (trig_hit) begin
          triggered_d = 1'b1;
          remaining_d = post_count;
          state_d     = (post_count == '0) ? FROZEN : POST;
        end
      end
      POST: begin
        if (accept) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = FROZEN;
        end
      end
      FROZEN:  state_d = FROZEN;
      default: state_d = ARMED;
    endcase
    dropped_d = (fifo_drop && dropped_q != 16'hFFFF) ? dropped_q + 16'd1 : dropped_q;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q     <= ARMED;
      remaining_q <= '0;
      triggered_q <= 1'b0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      triggered_q <= triggered_d;
      dropped_q   <= dropped_d;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  // Cycles since the last accepted event; reset/clear count as a time origin.
  logic [TS_W-1:0] delta_q, delta_d;

  always_comb begin
    if (accept)        delta_d = TS_W'(1);
    else if (&delta_q) delta_d = delta_q;
    else               delta_d = delta_q + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) delta_q <= TS_W'(1);
    else              delta_q <= delta_d;
  end

  assign rec = {delta_q, tif.ev_flags, tif.ev_rd, tif.ev_pc};
`else
  assign rec = {tif.ev_flags, tif.ev_rd, tif.ev_pc};
`endif

  tinyqv_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (clear),
    .mode_ring (mode_ring),
    .push      (accept),
    .pop_req   (tif.out_ready),
    .wdata     (rec),
    .rdata     (tif.out_data),
    .valid     (tif.out_valid),
    .level     (level),
    .drop      (fifo_drop)
  );

  assign dropped   = dropped_q;
  assign triggered = triggered_q;
  assign frozen    = (state_q == FROZEN);
endmodule

// File: tb/tb_tinyqv_trace_buffer.sv
// tb/tb_tinyqv_trace_buffer.sv - self-checking bench for tinyqv_trace_buffer
// Timestamp checks run only when TRACE_TIMESTAMP_EN is defined.
module tb_tinyqv_trace_buffer;
  import tinyqv_trace_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 23;
  localparam int TS_W   = 4;
  localparam int REC_W  = rec_width(ADDR_W, TS_W);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst, enable, mode_ring, clear, trig_en;
  logic [ADDR_W-1:0] trig_addr;
  logic [CNT_W-1:0]  post_count;
  logic [CNT_W-1:0]  level;
  logic [15:0]       dropped;
  logic              triggered, frozen;

  tinyqv_trace_if #(.ADDR_W(ADDR_W), .REC_W(REC_W)) tif ();

  tinyqv_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TS_W(TS_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode_ring  (mode_ring),
    .clear      (clear),
    .trig_en    (trig_en),
    .trig_addr  (trig_addr),
    .post_count (post_count),
    .tif        (tif),
    .level      (level),
    .dropped    (dropped),
    .triggered  (triggered),
    .frozen     (frozen)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of records plus trigger bookkeeping
  logic [REC_W-1:0] mq[$];
  int     m_dropped;
  bit     m_trig, m_frozen;
  int     m_left;
  longint cyc, last_acc;

  typedef struct {
    bit              en, c, v, rdy, clr;
    bit [ADDR_W-1:0] pc;
    int              exp_level;
    bit [ADDR_W-1:0] exp_pc;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mk_rec(input logic [ADDR_W-1:0] pc, input logic [3:0] rd,
                                              input logic [4:0] fl, input longint ts);
    logic [REC_W-1:0] r;
    r = '0;
    r[ADDR_W-1:0] = pc;
    r[rec_rd_lsb(ADDR_W) +: 4] = rd;
    r[rec_flg_lsb(ADDR_W) +: 5] = fl;
    if (TS_EN) r = r | (REC_W'(ts) << rec_ts_lsb(ADDR_W));
    return r;
  endfunction

  task automatic model_edge();
    bit     acc, pop;
    longint ts;
    cyc++;
    if (rst || clear) begin
      mq.delete();
      m_dropped = 0; m_trig = 0; m_frozen = 0; m_left = 0;
      last_acc = cyc;
      return;
    end
    acc = enable && tif.ev_complete && tif.ev_valid && !m_frozen;
    pop = (mq.size() != 0) && tif.out_ready;
    ts  = cyc - last_acc;
    if (ts > (2**TS_W) - 1) ts = (2**TS_W) - 1;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      if (mq.size() < DEPTH) mq.push_back(mk_rec(tif.ev_pc, tif.ev_rd, tif.ev_flags, ts));
      else if (mode_ring) begin
        void'(mq.pop_front());
        mq.push_back(mk_rec(tif.ev_pc, tif.ev_rd, tif.ev_flags, ts));
      end else if (m_dropped < 65535) m_dropped++;
      if (!m_trig) begin
        if (trig_en && tif.ev_pc == trig_addr) begin
          m_trig = 1;
          if (post_count == 0) m_frozen = 1;
          else m_left = int'(post_count);
        end
      end else if (!m_frozen) begin
        m_left--;
        if (m_left == 0) m_frozen = 1;
      end
      last_acc = cyc;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("m_level", 64'(level), 64'(mq.size()));
    chk("m_valid", 64'(tif.out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) chk("m_data", 64'(tif.out_data), 64'(mq[0]));
    chk("m_dropped", 64'(dropped), 64'(m_dropped));
    chk("m_triggered", 64'(triggered), 64'(m_trig));
    chk("m_frozen", 64'(frozen), 64'(m_frozen));
  endtask

  task automatic set_ev(input int pc);
    tif.ev_complete = 1'b1;
    tif.ev_valid    = 1'b1;
    tif.ev_pc       = ADDR_W'(pc);
    tif.ev_rd       = 4'($urandom);
    tif.ev_flags    = 5'($urandom);
  endtask

  task automatic idle();
    tif.ev_complete = 1'b0;
    tif.ev_valid    = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    tif.out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic drain_expect(input string name, input int first, input int step, input int n);
    idle();
    tif.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk(name, 64'(tif.out_data[ADDR_W-1:0]), 64'(first + i * step));
      tick();
    end
    tif.out_ready = 1'b0;
    chk({name, "_empty"}, 64'(level), 64'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode_ring = 1'b0; clear = 1'b0;
    trig_en = 1'b0; trig_addr = '0; post_count = '0;
    tif.ev_complete = 1'b0; tif.ev_valid = 1'b0; tif.ev_pc = '0;
    tif.ev_rd = '0; tif.ev_flags = '0; tif.out_ready = 1'b0;
    cyc = 0; last_acc = 0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(tif.out_valid), 64'd0);
    chk("rst_data", 64'(tif.out_data), 64'd0);
    chk("rst_dropped", 64'(dropped), 64'd0);
    chk("rst_triggered", 64'(triggered), 64'd0);
    chk("rst_frozen", 64'(frozen), 64'd0);

    // en c v rdy clr pc | level out_pc
    tbl[0] = '{1, 1, 1, 0, 0, 23'h10, 1, 23'h10};
    tbl[1] = '{1, 1, 0, 0, 0, 23'h11, 1, 23'h10};
    tbl[2] = '{0, 1, 1, 0, 0, 23'h12, 1, 23'h10};
    tbl[3] = '{1, 0, 1, 0, 0, 23'h13, 1, 23'h10};
    tbl[4] = '{1, 1, 1, 1, 0, 23'h14, 1, 23'h14};
    tbl[5] = '{0, 0, 0, 1, 0, 23'h00, 0, 23'h00};
    tbl[6] = '{1, 1, 1, 0, 1, 23'h15, 0, 23'h00};
    tbl[7] = '{1, 1, 1, 0, 0, 23'h16, 1, 23'h16};
    tbl[8] = '{1, 1, 1, 0, 0, 23'h17, 2, 23'h16};
    tbl[9] = '{0, 0, 0, 1, 0, 23'h00, 1, 23'h17};
    for (int i = 0; i < 10; i++) begin
      enable          = tbl[i].en;
      tif.ev_complete = tbl[i].c;
      tif.ev_valid    = tbl[i].v;
      tif.ev_pc       = tbl[i].pc;
      tif.out_ready   = tbl[i].rdy;
      clear           = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_level", i), 64'(level), 64'(tbl[i].exp_level));
      chk($sformatf("tbl%0d_valid", i), 64'(tif.out_valid), 64'(tbl[i].exp_level != 0));
      if (tbl[i].exp_level != 0)
        chk($sformatf("tbl%0d_pc", i), 64'(tif.out_data[ADDR_W-1:0]), 64'(tbl[i].exp_pc));
      chk($sformatf("tbl%0d_dropped", i), 64'(dropped), 64'd0);
    end
    clear = 1'b0;

    // Stream fill: 20 events into 16 slots, last 4 dropped
    do_clear();
    enable = 1'b1; mode_ring = 1'b0;
    for (int i = 0; i < 20; i++) begin set_ev(32'h100 + i); tick(); end
    idle();
    chk("stream_level", 64'(level), 64'd16);
    chk("stream_dropped", 64'(dropped), 64'd4);
    drain_expect("stream_pc", 32'h100, 1, 16);

    // Ring: oldest 4 overwritten
    do_clear();
    mode_ring = 1'b1;
    for (int i = 0; i < 20; i++) begin set_ev(32'h100 + i); tick(); end
    idle();
    chk("ring_level", 64'(level), 64'd16);
    chk("ring_dropped", 64'(dropped), 64'd0);
    drain_expect("ring_pc", 32'h104, 1, 16);

    // Push and pop together while full in stream mode
    do_clear();
    mode_ring = 1'b0;
    for (int i = 0; i < 16; i++) begin set_ev(32'h300 + i); tick(); end
    tif.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_ev(32'h310 + i);
      tick();
      chk("pp_level", 64'(level), 64'd16);
      chk("pp_dropped", 64'(dropped), 64'd0);
    end
    drain_expect("pp_pc", 32'h308, 1, 16);

    // Trigger at 0x200 with three post events
    do_clear();
    trig_en = 1'b1; trig_addr = 23'h200; post_count = CNT_W'(3);
    for (int i = 0; i < 6; i++) begin
      set_ev(32'h1FE + 2 * i);
      tick();
      chk($sformatf("trig_triggered%0d", i), 64'(triggered), 64'(i >= 1));
      chk($sformatf("trig_frozen%0d", i), 64'(frozen), 64'(i >= 4));
    end
    idle();
    chk("trig_level", 64'(level), 64'd5);
    drain_expect("trig_pc", 32'h1FE, 2, 5);
    chk("trig_frozen_after_drain", 64'(frozen), 64'd1);

    // clear beats a same-cycle matching event; buffer re-arms afterwards
    set_ev(32'h200);
    tif.out_ready = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0; tif.out_ready = 1'b0;
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_triggered", 64'(triggered), 64'd0);
    chk("clr_frozen", 64'(frozen), 64'd0);
    set_ev(32'h200);
    tick();
    idle();
    chk("rearm_triggered", 64'(triggered), 64'd1);
    chk("rearm_frozen", 64'(frozen), 64'd0);
    chk("rearm_level", 64'(level), 64'd1);
    trig_en = 1'b0;

`ifdef TRACE_TIMESTAMP_EN
    do_clear();
    set_ev(32'h40); tick(); idle();
    tick(); tick();
    set_ev(32'h41); tick(); idle();
    repeat (39) tick();
    set_ev(32'h42); tick(); idle();
    tif.out_ready = 1'b1;
    chk("ts_first", 64'(tif.out_data[rec_ts_lsb(ADDR_W) +: TS_W]), 64'd1); tick();
    chk("ts_gap3", 64'(tif.out_data[rec_ts_lsb(ADDR_W) +: TS_W]), 64'd3); tick();
    chk("ts_sat", 64'(tif.out_data[rec_ts_lsb(ADDR_W) +: TS_W]), 64'd15); tick();
    tif.out_ready = 1'b0;
`endif

    // Randomized segments against the model
    for (int seg = 0; seg < 6; seg++) begin
      do_clear();
      mode_ring  = 1'($urandom);
      trig_en    = (seg % 2) == 1;
      trig_addr  = ADDR_W'($urandom_range(0, 7));
      post_count = CNT_W'($urandom_range(0, 20));
      for (int c = 0; c < 300; c++) begin
        enable          = ($urandom % 10) != 0;
        tif.ev_complete = ($urandom % 4) != 0;
        tif.ev_valid    = ($urandom % 4) != 0;
        tif.ev_pc       = ADDR_W'($urandom_range(0, 7));
        tif.ev_rd       = 4'($urandom);
        tif.ev_flags    = 5'($urandom);
        tif.out_ready   = ($urandom % 6) < (seg % 3) + 1;
        clear           = ($urandom % 150) == 0;
        rst             = ($urandom % 400) == 0;
        if (($urandom % 50) == 0) mode_ring = ~mode_ring;
        tick();
        check_model();
      end
      clear = 1'b0;
      rst   = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tinyqv_trace_buffer.md
Name: tinyqv_trace_buffer

Overview:
Parametrised retired-instruction trace buffer that records the tinyQV CPU debug outputs into on-chip storage.
- Sits beside tinyqv_cpu in simulation and FPGA bring-up wrappers.
- Captures one record per valid completed instruction; supports stream or ring capture and a PC trigger that freezes the buffer after N further events.
- Records are drained over a valid/ready port.

Parameters:
DEPTH, 16, number of trace records; power of 2, minimum 2
ADDR_W, 23, width of captured PC (halfword address, bits [23:1])
TS_W, 12, timestamp delta width (used only with TRACE_TIMESTAMP_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  capture enable
mode_ring  in  1  0 = stream (drop when full), 1 = ring (overwrite oldest)
clear  in  1  synchronous flush: empties buffer, clears dropped/triggered, returns to ARMED
trig_en  in  1  arm PC trigger
trig_addr  in  ADDR_W  trigger PC
post_count  in  $clog2(DEPTH)+1  events to capture after the trigger event
ev_complete  in  1  debug_instr_complete
ev_valid  in  1  debug_instr_valid
ev_pc  in  ADDR_W  PC of completing instruction
ev_rd  in  4  debug_rd
ev_flags  in  5  {interrupt_pending, reg_wen, ret, early_branch, branch}
out_valid  out  1  buffer non-empty
out_ready  in  1  consumer pop
out_data  out  REC_W  oldest record: {[ts], flags, rd, pc}; REC_W = ADDR_W+9 (+TS_W with timestamps)
level  out  $clog2(DEPTH)+1  records held
dropped  out  16  events lost in stream mode, saturating
triggered  out  1  trigger has fired
frozen  out  1  capture stopped

Behaviour:
- Reset (rst=1): all outputs 0; pointers 0; state ARMED. clear has identical effect and overrides any same-cycle event or pop.
- Accept condition: enable & ev_complete & ev_valid & state != FROZEN.
- Write latency: a record accepted in cycle N is visible on out_data/out_valid at cycle N+1; level updates at N+1.
- out_valid = (level != 0). out_data = storage[rd_ptr], combinational from the array, stable while out_valid & !out_ready. Pop occurs on out_valid & out_ready.
- Push + pop in the same cycle: both occur in any level, including full; level is unchanged.
- Full, push, no pop, stream mode: event discarded; dropped += 1, saturating at 16'hFFFF.
- Full, push, no pop, ring mode: oldest record overwritten; rd_ptr advances; level stays DEPTH; dropped unchanged.
- Pointers wrap modulo DEPTH.
- State machine:
  - ARMED: captures normally. If trig_en and the accepted event's ev_pc == trig_addr: event is written, triggered <= 1, remaining <= post_count. Next state is FROZEN if post_count == 0, else POST.
  - POST: each accepted event is written and decrements remaining; the event that takes remaining to 0 is written and the state becomes FROZEN.
  - FROZEN: frozen = 1, no capture; draining is still allowed. Exits only on clear or rst.
- Trigger match is only tested in ARMED; a matching PC in POST is an ordinary event.
- A trigger event dropped in stream-full is still a trigger: triggered sets and dropped increments.
- enable low: events ignored; state, trigger and remaining counter are held.

Optional Feature:
TRACE_TIMESTAMP_EN:
- Defined: a free-running cycle counter runs from reset. Each record's top TS_W bits hold the cycles since the previous accepted event, saturating at all-ones. The delta restarts after each accepted event, including dropped ones, and on clear. The first record after reset/clear holds cycles since reset/clear.
- Undefined: no counter; REC_W = ADDR_W+9 (32 by default).

Decomposition:
- Package tinyqv_trace_pkg: flag bit indices (FLG_BRANCH=0 .. FLG_IRQ=4), state enum {ARMED, POST, FROZEN}, record field offset constants.
- Sub-module tinyqv_trace_fifo: storage array, pointers, level, stream/ring full policy. The parent holds trigger FSM, drop counter and timestamp.

Test Plan:
- Stream fill: enable, 20 valid events PC 0x100..0x113, no pops -> level=16, dropped=4; drained out_data PCs 0x100..0x10F in order.
- Ring overwrite: same stimulus with mode_ring=1 -> level=16, dropped=0; drained PCs 0x104..0x113.
- Trigger: trig_en, trig_addr=0x200, post_count=3, PCs 0x1FE,0x200,0x202,0x204,0x206,0x208 -> triggered after the 0x200 event, frozen after 0x206; 5 records, last PC 0x206.
- Simultaneous push/pop at full, stream mode, out_ready=1 for 8 cycles with events -> level stays 16, dropped unchanged.
- ev_complete=1 with ev_valid=0, and enable=0 cases -> no record written, level unchanged; clear asserted together with an event -> level=0, triggered=0, state ARMED.
- TRACE_TIMESTAMP_EN, TS_W=4: events 3 cycles apart, then a 40-cycle gap -> ts fields 3 then 15 (saturated).
